// File: rtl/ifetch_buf_pkg.sv
// Shared widths, encodings and the fetch-buffer entry type.
// Imported by the fetch buffer and by anything that talks to it.
package ifetch_buf_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [DATA_WIDTH-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_WIDTH-1:0] next_pc(
        input logic [ADDR_WIDTH-1:0] pc
    );
        return pc + ADDR_WIDTH'(4);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage array plus wrapping pointers and count.
// Ports: clk_i, rst_i (async, high), clear_i (sync flush), push_i/data_i,
//        pop_i, data_o (head, straight from storage), count_o.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow; a clear cancels both.
    assign do_push = push_i && !clear_i && (count != CW'(DEPTH));
    assign do_pop  = pop_i && !clear_i && (count != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the control state above does.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

    assign data_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer between pc/imem port and if_id.
// Ports: clk_i, rst_i, flush_jump_i/new_pc_i (redirect), inst_ce_o/pc_o
//        (imem request), inst_i (data one cycle later), inst_valid_o/
//        inst_o/inst_addr_o/inst_ready_i (head handshake to if_id).
module ifetch_buf
    import ifetch_buf_pkg::*;
#(
    parameter int                    DEPTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_jump_i,
    input  logic [ADDR_WIDTH-1:0] new_pc_i,
    output logic                  inst_ce_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic [DATA_WIDTH-1:0] inst_i,
    output logic                  inst_valid_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    input  logic                  inst_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  inflight;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;
    logic                  valid;
    fetch_entry_t          wr_entry;
    fetch_entry_t          head;

    // Reserve a slot for the in-flight word so a push can never overflow.
    assign inst_ce_o = !rst_i && !flush_jump_i &&
                       ((count + CW'(inflight)) < CW'(DEPTH));
    assign pc_o      = fetch_pc;

    assign valid = (count != '0);
    assign push  = inflight && !flush_jump_i;
    assign pop   = valid && inst_ready_i && !flush_jump_i;

    assign wr_entry = '{addr: pend_addr, inst: inst_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc  <= RESET_PC;
            pend_addr <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= inst_ce_o;
            if (flush_jump_i) begin
                fetch_pc <= new_pc_i;
            end else if (inst_ce_o) begin
                fetch_pc  <= next_pc(fetch_pc);
                pend_addr <= fetch_pc;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_jump_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (wr_entry),
        .data_o  (head),
        .count_o (count)
    );

    // Storage is unreset, so mask the head while empty.
    assign inst_valid_o = valid;
    assign inst_o       = valid ? head.inst : '0;
    assign inst_addr_o  = valid ? head.addr : '0;

endmodule

// File: doc/ifetch_buf.md
IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered instruction entries; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 flush_jump_i  input  1  redirect; discard all buffered and in-flight instructions.
REQ-006 new_pc_i  input  ADDR_WIDTH  redirect target, sampled when flush_jump_i=1.
REQ-007 inst_ce_o  output  1  instruction-memory read request.
REQ-008 pc_o  output  ADDR_WIDTH  instruction-memory read address; meaningful when inst_ce_o=1.
REQ-009 inst_i  input  DATA_WIDTH  memory read data, valid exactly one cycle after the request.
REQ-010 inst_valid_o  output  1  head entry is valid.
REQ-011 inst_o  output  DATA_WIDTH  head instruction word.
REQ-012 inst_addr_o  output  ADDR_WIDTH  head instruction address.
REQ-013 inst_ready_i  input  1  downstream (if_id, driven from !stall) accepts the head this cycle.

Function
REQ-014 Memory request SHALL be issued (inst_ce_o=1) when count + inflight < DEPTH and flush_jump_i=0; the fetch PC advances by 4 on every issued request.
REQ-015 inflight SHALL be 1 in the cycle after an issued request, else 0; its address SHALL be held in a pending-address register.
REQ-016 When inflight=1 and not flushed, {inst_i, pending address} SHALL be pushed into the FIFO at the end of that cycle.
REQ-017 Pop SHALL occur when inst_valid_o=1 and inst_ready_i=1; the next entry appears on outputs the following cycle.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-019 inst_valid_o SHALL equal (count != 0); inst_o/inst_addr_o SHALL reflect the head directly from storage, without combinational path from inst_i.
REQ-020 Latency: a request issued in cycle N SHALL reach inst_valid_o in cycle N+2 when the FIFO is empty.
REQ-021 Throughput: with inst_ready_i held at 1, SHALL deliver one instruction per cycle, sustained.
REQ-022 Full: count + inflight never exceeds DEPTH; no push SHALL be dropped and no overflow SHALL occur.
REQ-023 Empty with inst_ready_i=1: no pop; count SHALL stay 0.
REQ-024 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-025 Flush cycle: count:=0, pointers:=0, inflight cleared, fetch PC:=new_pc_i, no request issued, and any pop or push in that cycle SHALL be ignored.
REQ-026 Cycle after flush: request at new_pc_i SHALL be issued; the stale inst_i returning that cycle SHALL be discarded.
REQ-027 Back-to-back flushes: the last flush's new_pc_i wins.

Reset
REQ-028 On rst_i=1, regardless of clock: fetch PC:=RESET_PC, count:=0, pointers:=0, inflight:=0.
REQ-029 Outputs during reset: inst_ce_o=0, inst_valid_o=0, inst_o=0, inst_addr_o=0, pc_o=RESET_PC.
REQ-030 Reset asserted mid-operation SHALL discard all entries and the in-flight request; after release, fetch SHALL restart at RESET_PC on the first clock edge.
REQ-031 The FIFO storage array SHALL be exempt from reset; only the control state is reset.

Structure
REQ-032 ADDR_WIDTH, DATA_WIDTH and the NOP encoding SHALL come from the shared defines; no local redefinition.
REQ-033 Storage and pointers SHALL be one sub-module, sync_fifo (parameterized width/depth, push/pop/clear, count out); fetch control SHALL live in ifetch_buf.
REQ-034 The block SHALL sit between pc_reg/dpram instruction port and if_id, replacing direct pc-to-if_id wiring.

Verification
REQ-035 Reset release, inst_ready_i=1, memory returns addr-as-data: requests at 0x0, 0x4, 0x8 in cycles 0, 1, 2; inst_valid_o from cycle 2 with inst_addr_o=0x0, 0x4, 0x8 consecutively.
REQ-036 inst_ready_i=0 for 10 cycles: exactly DEPTH=4 entries held (0x0–0xC), inst_ce_o=0 once full; on release, 0x0–0xC followed by 0x10 with no gap or duplicate.
REQ-037 flush_jump_i=1 with new_pc_i=0x100 while 3 entries are buffered and 1 is in flight: next-cycle inst_valid_o=0, request at 0x100, first output 0x100 two cycles after that; 0x0–0xC never appear.
REQ-038 Flush in the same cycle as a pop and a push: count=0 after; no stale entry is emitted.
REQ-039 rst_i pulsed asynchronously mid-stream between edges: outputs zero immediately; fetch restarts at RESET_PC.
REQ-040 Random inst_ready_i toggling for 1000 cycles with periodic flushes: the emitted address sequence matches the reference model (sequential +4, redirect on flush), and pointer wrap is exercised.
